// File: rtl/fechadura_pkg.sv
// Shared types and defaults for the pulse stretcher and its cycle counter.
package fechadura_pkg;

    // Sequencer states, 2-bit encoded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        FIM  = 2'd3
    } estado_stretch_t;

    // Default timing: ON/OFF lengths in clk cycles, repetitions per trigger.
    localparam int T_ON_DEF  = 5000;
    localparam int T_OFF_DEF = 2500;
    localparam int N_REP_DEF = 3;

    // Counter and repetition widths; both cover the largest legal parameter.
    localparam int CONT_W = 13;
    localparam int REP_W  = 4;

endpackage

// File: rtl/contador_tempo.sv
// 13-bit phase cycle counter with clear/enable and a terminal-match flag.
// fim is high while the count equals limite, so the owner can change phase
// on the same edge that would otherwise take the count past the limit.
module contador_tempo
    import fechadura_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [CONT_W-1:0] limite,
    output logic              fim
);

    logic [CONT_W-1:0] cont;

    // Count up while enabled; clear has priority over enable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cont <= '0;
        end else if (clr) begin
            cont <= '0;
        end else if (en) begin
            cont <= cont + 1'b1;
        end
    end

    assign fim = (cont == limite);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into N_REP bursts of T_ON high cycles
// separated by T_OFF low cycles, then pulses done for one cycle.
// Optional build macro: PULSE_STRETCHER_RETRIGGER_EN -- when defined, a new
// trigger during ON or OFF restarts the sequence from the first ON cycle.
// A trigger is accepted only once per assertion of pulso_in: the input must
// drop low before it can start (or restart) another sequence.
module pulse_stretcher
    import fechadura_pkg::*;
#(
    parameter int T_ON  = T_ON_DEF,
    parameter int T_OFF = T_OFF_DEF,
    parameter int N_REP = N_REP_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pulso_in,
    output logic saida,
    output logic busy,
    output logic done
);

    // Terminal counts: a phase ends on the cycle the counter reaches length-1.
    localparam logic [CONT_W-1:0] T_ON_LIM  = CONT_W'(T_ON - 1);
    localparam logic [CONT_W-1:0] T_OFF_LIM = CONT_W'(T_OFF - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(N_REP - 1);

    estado_stretch_t   state;
    logic [REP_W-1:0]  rep;
    logic              armed;
    logic              aceita;
    logic              fim_fase;
    logic              cont_clr;
    logic              cont_en;
    logic [CONT_W-1:0] limite;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    // Trigger accepted in IDLE, ON and OFF; FIM always completes.
    assign aceita = pulso_in && armed && (state != FIM);
`else
    // Trigger accepted only in IDLE.
    assign aceita = pulso_in && armed && (state == IDLE);
`endif

    // Counter runs only in ON/OFF and restarts at every phase boundary.
    assign cont_en  = (state == ON) || (state == OFF);
    assign cont_clr = (state == IDLE) || (state == FIM) || fim_fase || aceita;
    assign limite   = (state == OFF) ? T_OFF_LIM : T_ON_LIM;

    contador_tempo u_contador (
        .clk    (clk),
        .rst    (rst),
        .clr    (cont_clr),
        .en     (cont_en),
        .limite (limite),
        .fim    (fim_fase)
    );

    // Sequencer FSM plus repetition count and trigger re-arm tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rep   <= '0;
            armed <= 1'b1;
        end else begin
            if (aceita) begin
                armed <= 1'b0;
            end else if (!pulso_in) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (aceita) begin
                        state <= ON;
                        rep   <= '0;
                    end
                end
                ON: begin
                    if (aceita) begin
                        state <= ON;
                        rep   <= '0;
                    end else if (fim_fase) begin
                        state <= OFF;
                    end
                end
                OFF: begin
                    if (aceita) begin
                        state <= ON;
                        rep   <= '0;
                    end else if (fim_fase) begin
                        if (rep != REP_LAST) begin
                            state <= ON;
                            rep   <= rep + 1'b1;
                        end else begin
                            state <= FIM;
                        end
                    end
                end
                FIM: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register.
    assign saida = (state == ON);
    assign busy  = (state != IDLE);
    assign done  = (state == FIM);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher with T_ON=4, T_OFF=2, N_REP=2.
// Directed per-cycle tables for the timing scenarios, then randomized
// stimulus against an offset-based reference model.
module tb_pulse_stretcher;

    localparam int P_ON  = 4;
    localparam int P_OFF = 2;
    localparam int P_REP = 2;
    localparam int PER   = P_ON + P_OFF;
    localparam int SEQ_L = P_REP * PER;   // offset of the FIM cycle

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk;
    logic rst;
    logic pulso_in;
    logic saida;
    logic busy;
    logic done;

    int tests_run;
    int tests_failed;

    pulse_stretcher #(
        .T_ON  (P_ON),
        .T_OFF (P_OFF),
        .N_REP (P_REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pulso_in (pulso_in),
        .saida    (saida),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: inputs driven in that cycle, outputs expected in it.
    typedef struct packed {
        logic rst;
        logic pulso;
        logic saida;
        logic busy;
        logic done;
    } vec_t;

    localparam int K_RST   = 0;
    localparam int K_PULSO = 1;
    localparam int K_SAIDA = 2;
    localparam int K_BUSY  = 3;
    localparam int K_DONE  = 4;

    vec_t vecs [0:63];
    int   nvec;

    task automatic check(input string name, input int cyc, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Start a new table of n cycles; cycles 0..2 hold reset.
    task automatic new_table(input int n);
        for (int c = 0; c < 64; c++) vecs[c] = '0;
        nvec = n;
        for (int c = 0; c < 3; c++) vecs[c].rst = 1'b1;
    endtask

    task automatic mark(input int kind, input int lo, input int hi);
        for (int c = lo; c <= hi; c++) begin
            case (kind)
                K_RST:   vecs[c].rst   = 1'b1;
                K_PULSO: vecs[c].pulso = 1'b1;
                K_SAIDA: vecs[c].saida = 1'b1;
                K_BUSY:  vecs[c].busy  = 1'b1;
                default: vecs[c].done  = 1'b1;
            endcase
        end
    endtask

    // Called #1 after a rising edge. Cycle 0 outputs reflect the previous
    // run and are not checked.
    task automatic apply_table(input string name);
        for (int c = 0; c < nvec; c++) begin
            rst      = vecs[c].rst;
            pulso_in = vecs[c].pulso;
            if (c > 0) begin
                check({name, ".saida"}, c, saida, vecs[c].saida);
                check({name, ".busy"},  c, busy,  vecs[c].busy);
                check({name, ".done"},  c, done,  vecs[c].done);
            end
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        pulso_in = 1'b0;
    endtask

    // Reference model: a sequence is an offset t from its first ON cycle.
    bit m_act;
    int m_t;
    bit m_held;   // pulso_in has stayed high since it was last accepted

    task automatic model_edge(input logic r, input logic p);
        bit acc;
        if (r) begin
            m_act  = 1'b0;
            m_held = 1'b0;
        end else begin
            acc = p && !m_held && (!m_act || (RETRIG && m_t < SEQ_L));
            if (acc) begin
                m_act  = 1'b1;
                m_t    = 0;
                m_held = 1'b1;
            end else begin
                if (!p) m_held = 1'b0;
                if (m_act) begin
                    if (m_t == SEQ_L) m_act = 1'b0;
                    else              m_t   = m_t + 1;
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        pulso_in     = 1'b0;
        @(posedge clk);
        #1;

        // Single pulse at 10, plus rst+pulso together at 5 staying IDLE.
        new_table(27);
        mark(K_RST, 5, 5);
        mark(K_PULSO, 5, 5);
        mark(K_PULSO, 10, 10);
        mark(K_SAIDA, 11, 14);
        mark(K_SAIDA, 17, 20);
        mark(K_BUSY, 11, 23);
        mark(K_DONE, 23, 23);
        apply_table("single");

        // Held trigger 10..30 starts exactly one sequence.
        new_table(34);
        mark(K_PULSO, 10, 30);
        mark(K_SAIDA, 11, 14);
        mark(K_SAIDA, 17, 20);
        mark(K_BUSY, 11, 23);
        mark(K_DONE, 23, 23);
        apply_table("held");

        // Reset mid-ON at 13, new pulse at 16.
        new_table(31);
        mark(K_PULSO, 10, 10);
        mark(K_RST, 13, 13);
        mark(K_PULSO, 16, 16);
        mark(K_SAIDA, 11, 13);
        mark(K_SAIDA, 17, 20);
        mark(K_SAIDA, 23, 26);
        mark(K_BUSY, 11, 13);
        mark(K_BUSY, 17, 29);
        mark(K_DONE, 29, 29);
        apply_table("rst_mid");

        // Second pulse during OFF at 16.
        new_table(31);
        mark(K_PULSO, 10, 10);
        mark(K_PULSO, 16, 16);
        mark(K_SAIDA, 11, 14);
        if (RETRIG) begin
            mark(K_SAIDA, 17, 20);
            mark(K_SAIDA, 23, 26);
            mark(K_BUSY, 11, 29);
            mark(K_DONE, 29, 29);
        end else begin
            mark(K_SAIDA, 17, 20);
            mark(K_BUSY, 11, 23);
            mark(K_DONE, 23, 23);
        end
        apply_table("off_pulse");

        // Pulse in FIM (23) ignored, pulse at 24 accepted.
        new_table(40);
        mark(K_PULSO, 10, 10);
        mark(K_PULSO, 23, 24);
        mark(K_SAIDA, 11, 14);
        mark(K_SAIDA, 17, 20);
        mark(K_SAIDA, 25, 28);
        mark(K_SAIDA, 31, 34);
        mark(K_BUSY, 11, 23);
        mark(K_BUSY, 25, 37);
        mark(K_DONE, 23, 23);
        mark(K_DONE, 37, 37);
        apply_table("fim_pulse");

        // Randomized run against the reference model.
        m_act  = 1'b0;
        m_t    = 0;
        m_held = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            check("rnd.saida", i, saida, m_act && m_t < SEQ_L && (m_t % PER) < P_ON);
            check("rnd.busy",  i, busy,  m_act);
            check("rnd.done",  i, done,  m_act && m_t == SEQ_L);
            rst      = (i == 0) || ($urandom_range(0, 299) == 0);
            pulso_in = ($urandom_range(0, 99) < 6) ||
                       (pulso_in && $urandom_range(0, 3) != 0);
            @(posedge clk);
            model_edge(rst, pulso_in);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
